// File: rtl/cei_mochila_pkg.sv
// Shared types for the redundant-hart request path: OBI request struct,
// voter mode encoding and hart index.
package cei_mochila_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef enum logic [1:0] {
    TMR      = 2'd0,
    DEGRADED = 2'd1,
    FAIL     = 2'd2
  } voter_mode_e;

  typedef logic [1:0] hart_idx_t;

  function automatic obi_req_t maj3(obi_req_t a, obi_req_t b, obi_req_t c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_voter_lane.sv
// One request channel: mode-dependent vote of three hart requests and the
// raw per-hart disagreement against the voted value.
module tmr_voter_lane
  import cei_mochila_pkg::*;
(
  input  obi_req_t    req0_i,
  input  obi_req_t    req1_i,
  input  obi_req_t    req2_i,
  input  voter_mode_e mode_i,
  input  hart_idx_t   excl_i,
  output obi_req_t    voted_o,
  output logic [2:0]  mis_o
);

  obi_req_t h [3];
  assign h[0] = req0_i;
  assign h[1] = req1_i;
  assign h[2] = req2_i;

  always_comb begin
    voted_o = '0;
    case (mode_i)
      TMR:      voted_o = maj3(req0_i, req1_i, req2_i);
      DEGRADED: voted_o = (excl_i == 2'd0) ? req1_i : req0_i;
      default:  voted_o = '0;
    endcase
  end

  // addr only matters for an issuing hart, wdata only for a writing hart
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mis_o[i] = (voted_o.req | h[i].req) &
                 (((voted_o.addr  != h[i].addr)  & h[i].req) |
                  ((voted_o.wdata != h[i].wdata) & h[i].we)  |
                  (voted_o.be  != h[i].be) |
                  (voted_o.we  != h[i].we) |
                  (voted_o.req != h[i].req));
    end
  end

endmodule

// File: rtl/tmr_degrading_voter.sv
// TMR request voter that degrades to dual-lockstep after a persistent
// single-hart fault and fails on any further disagreement.
module tmr_degrading_voter
  import cei_mochila_pkg::*;
#(
  parameter int NHARTS = 3,
  parameter int NCH    = 2,
  parameter int CNT_W  = 4,
  parameter int THRESH = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  obi_req_t [NCH-1:0][NHARTS-1:0]       core_req_i,
  output obi_req_t [NCH-1:0]                   voted_req_o,
  input  logic                                 enable_i,
  input  logic                                 resync_i,
  input  logic                                 clear_i,
  output logic [1:0]                           mode_o,
  output logic [1:0]                           faulty_hart_o,
  output logic                                 error_o,
  output logic [NHARTS-1:0]                    error_status_o,
  output logic                                 fatal_o
);

  if (NHARTS != 3) begin : g_bad_nharts
    $error("tmr_degrading_voter supports NHARTS == 3 only");
  end
  if (THRESH < 1 || THRESH > (2**CNT_W) - 1) begin : g_bad_thresh
    $error("tmr_degrading_voter THRESH out of range 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  voter_mode_e                    mode_q, mode_d;
  hart_idx_t                      faulty_q, faulty_d;
  logic                           error_q, error_d;
  logic [NHARTS-1:0]              status_q, status_d;
  logic [NHARTS-1:0][CNT_W-1:0]   cnt_q, cnt_d;

  logic [NCH-1:0][2:0]            lane_mis;
  logic [NHARTS-1:0]              hart_mis, mask, hit;
  hart_idx_t                      hit_idx;
  int unsigned                    nhit;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    tmr_voter_lane u_lane (
      .req0_i  (core_req_i[c][0]),
      .req1_i  (core_req_i[c][1]),
      .req2_i  (core_req_i[c][2]),
      .mode_i  (mode_q),
      .excl_i  (faulty_q),
      .voted_o (voted_req_o[c]),
      .mis_o   (lane_mis[c])
    );
  end

  always_comb begin
    mask     = enable_i && (mode_q != FAIL) ? '1 : '0;
    hart_mis = '0;
    for (int h = 0; h < NHARTS; h++) begin
      if (mode_q == DEGRADED && faulty_q == hart_idx_t'(h)) mask[h] = 1'b0;
      for (int c = 0; c < NCH; c++) hart_mis[h] = hart_mis[h] | lane_mis[c][h];
    end
    hart_mis = hart_mis & mask;

    hit     = '0;
    nhit    = 0;
    hit_idx = '0;
    for (int h = 0; h < NHARTS; h++) begin
      cnt_d[h] = hart_mis[h] ? ((cnt_q[h] == CNT_MAX) ? cnt_q[h] : cnt_q[h] + 1'b1) : '0;
      if (!mask[h] || resync_i) cnt_d[h] = '0;
      hit[h] = hart_mis[h] && (cnt_q[h] == CNT_HIT);
      if (hit[h]) begin
        nhit    = nhit + 1;
        hit_idx = hart_idx_t'(h);
      end
    end

    mode_d   = mode_q;
    faulty_d = faulty_q;
    case (mode_q)
      TMR: begin
        if (nhit >= 2) mode_d = FAIL;
        else if (nhit == 1) begin
          mode_d   = DEGRADED;
          faulty_d = hit_idx;
        end
      end
      DEGRADED: if (|hart_mis) mode_d = FAIL;
      default: ;
    endcase
    // resync dominates any fault seen in the same cycle
    if (resync_i) begin
      mode_d   = TMR;
      faulty_d = '0;
    end

    error_d  = |hart_mis;
    status_d = (clear_i ? '0 : status_q) | hart_mis;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q   <= TMR;
      faulty_q <= '0;
      error_q  <= 1'b0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      faulty_q <= faulty_d;
      error_q  <= error_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mode_o         = mode_q;
  assign faulty_hart_o  = faulty_q;
  assign error_o        = error_q;
  assign error_status_o = status_q;
  assign fatal_o        = (mode_q == FAIL);

endmodule

// File: tb/tb_tmr_degrading_voter.sv
// Scoreboard bench for tmr_degrading_voter: expectations are queued with the
// stimulus and checked on the falling edge of the cycle they fall due.
module tb_tmr_degrading_voter;
  import cei_mochila_pkg::*;

  localparam int NH = 3;
  localparam int NC = 2;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  obi_req_t [NC-1:0][NH-1:0]  core_req;
  obi_req_t [NC-1:0]          voted;
  logic                       enable_i, resync_i, clear_i;
  logic [1:0]                 mode_o, faulty_hart_o;
  logic                       error_o, fatal_o;
  logic [NH-1:0]              error_status_o;

  tmr_degrading_voter #(.NHARTS(3), .NCH(2), .CNT_W(4), .THRESH(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .core_req_i     (core_req),
    .voted_req_o    (voted),
    .enable_i       (enable_i),
    .resync_i       (resync_i),
    .clear_i        (clear_i),
    .mode_o         (mode_o),
    .faulty_hart_o  (faulty_hart_o),
    .error_o        (error_o),
    .error_status_o (error_status_o),
    .fatal_o        (fatal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
    int          due;
  } sb_t;

  localparam int S_ADDR0 = 0, S_REQ0 = 1, S_REQ1 = 2, S_MODE = 3, S_FAULTY = 4,
                 S_ERR = 5, S_STAT = 6, S_FATAL = 7, S_WDATA0 = 8, S_BE0 = 9;

  sb_t sb_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      S_ADDR0:  return 64'(voted[0].addr);
      S_REQ0:   return 64'(voted[0].req);
      S_REQ1:   return 64'(voted[1].req);
      S_MODE:   return 64'(mode_o);
      S_FAULTY: return 64'(faulty_hart_o);
      S_ERR:    return 64'(error_o);
      S_STAT:   return 64'(error_status_o);
      S_FATAL:  return 64'(fatal_o);
      S_WDATA0: return 64'(voted[0].wdata);
      S_BE0:    return 64'(voted[0].be);
      default:  return 64'hx;
    endcase
  endfunction

  always @(negedge clk_i) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        chk(sb_q[i].tag, obs(sb_q[i].sel), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  task automatic push(input string tag, input int sel, input logic [63:0] exp, input int d);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp; e.due = cyc + d;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic base();
    for (int h = 0; h < NH; h++) begin
      core_req[0][h] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0};
      core_req[1][h] = '0;
    end
    resync_i = 1'b0;
    clear_i  = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1;
    base();
    step(); step();
    chk("rst_mode", 64'(mode_o), 0);
    chk("rst_err", 64'(error_o), 0);
    chk("rst_stat", 64'(error_status_o), 0);
    chk("rst_fatal", 64'(fatal_o), 0);
    rst_i = 1'b0;

    // 1: all agree
    step(); base();
    push("t1_addr", S_ADDR0, 64'h100, 0);
    push("t1_req", S_REQ0, 1, 0);
    push("t1_err", S_ERR, 0, 1);
    push("t1_mode", S_MODE, 0, 1);

    // 2: single-cycle addr upset on hart1
    step(); core_req[0][1].addr = 32'h104;
    push("t2_addr", S_ADDR0, 64'h100, 0);
    push("t2_err", S_ERR, 1, 1);
    push("t2_stat", S_STAT, 3'b010, 1);
    push("t2_mode", S_MODE, 0, 1);
    step(); base();
    push("t2_clean_err", S_ERR, 0, 1);
    // 2+2 mismatches split by a clean cycle must not reach threshold
    for (int r = 0; r < 2; r++) begin
      step(); core_req[0][1].addr = 32'h104;
      step(); core_req[0][1].addr = 32'h104;
      step(); base();
    end
    push("t2_cnt_clear_mode", S_MODE, 0, 1);
    step(); clear_i = 1'b1;
    push("t2_clear_stat", S_STAT, 0, 1);

    // 3: wdata mismatch with we=0 is ignored
    for (int r = 0; r < 3; r++) begin
      step(); base();
      for (int h = 0; h < NH; h++) core_req[0][h].wdata = 32'hBEEF;
      core_req[0][2].wdata = 32'hDEAD;
      push("t3_we0_err", S_ERR, 0, 1);
    end
    push("t3_we0_mode", S_MODE, 0, 1);
    // 3: wdata mismatch with we=1 for 3 cycles degrades on hart2
    for (int r = 0; r < 3; r++) begin
      step();
      for (int h = 0; h < NH; h++) core_req[0][h].we = 1'b1;
      push("t3_err", S_ERR, 1, 1);
      push("t3_wdata", S_WDATA0, 64'hBEEF, 0);
      if (r < 2) push("t3_mode_tmr", S_MODE, 0, 1);
    end
    push("t3_mode_deg", S_MODE, 1, 1);
    push("t3_faulty", S_FAULTY, 2, 1);
    step();
    push("t3_deg_wdata", S_WDATA0, 64'hBEEF, 0);
    push("t3_deg_err", S_ERR, 0, 1);
    push("t3_deg_mode", S_MODE, 1, 1);

    // 4: any remaining disagreement in DEGRADED is fatal
    step(); core_req[0][1].be = 4'h3;
    push("t4_be", S_BE0, 64'hF, 0);
    push("t4_mode", S_MODE, 2, 1);
    push("t4_fatal", S_FATAL, 1, 1);
    push("t4_stat", S_STAT, 3'b110, 1);
    step(); base();
    for (int h = 0; h < NH; h++) core_req[1][h].req = 1'b1;
    push("t4_req0", S_REQ0, 0, 0);
    push("t4_req1", S_REQ1, 0, 0);
    push("t4_err", S_ERR, 0, 1);
    push("t4_mode_hold", S_MODE, 2, 1);

    // 5: resync returns to TMR, status sticky until clear
    step(); base(); resync_i = 1'b1;
    push("t5_mode", S_MODE, 0, 1);
    push("t5_fatal", S_FATAL, 0, 1);
    push("t5_stat_keep", S_STAT, 3'b110, 1);
    step(); base(); clear_i = 1'b1; core_req[0][0].addr = 32'h200;
    push("t5_set_clr_stat", S_STAT, 3'b001, 1);
    push("t5_err", S_ERR, 1, 1);
    step(); base(); core_req[0][0].addr = 32'h200;
    push("t5_cnt_mode", S_MODE, 0, 1);
    step(); base(); core_req[0][0].addr = 32'h200;
    push("t5_deg_mode", S_MODE, 1, 1);
    push("t5_deg_faulty", S_FAULTY, 0, 1);
    step(); base(); core_req[0][0].addr = 32'h200;
    push("t5_deg_vote", S_ADDR0, 64'h100, 0);
    step(); base(); enable_i = 1'b0; core_req[0][2].addr = 32'h104;
    push("t5_dis_err", S_ERR, 0, 1);
    push("t5_dis_mode", S_MODE, 1, 1);

    // 6a: asynchronous reset mid-DEGRADED
    step(); base(); enable_i = 1'b1;
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_mode", 64'(mode_o), 0);
    chk("t6_rst_faulty", 64'(faulty_hart_o), 0);
    chk("t6_rst_stat", 64'(error_status_o), 0);
    chk("t6_rst_err", 64'(error_o), 0);
    chk("t6_rst_fatal", 64'(fatal_o), 0);
    step(); rst_i = 1'b0;

    // 6b: two harts hitting threshold together go straight to fatal
    for (int r = 0; r < 3; r++) begin
      step(); base();
      core_req[0][1].addr = 32'h104;
      core_req[0][2].addr = 32'h108;
      push("t6_vote", S_ADDR0, 64'h100, 0);
      if (r < 2) push("t6_mode_tmr", S_MODE, 0, 1);
    end
    push("t6_mode_fail", S_MODE, 2, 1);
    push("t6_fatal", S_FATAL, 1, 1);
    push("t6_faulty", S_FAULTY, 0, 1);
    push("t6_stat", S_STAT, 3'b110, 1);

    step(); base();
    step(); step();
    chk("late_entries", 64'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_degrading_voter.md
Name: tmr_degrading_voter

Overview:
Successor to the combinational triple-modular-redundancy (TMR) OBI request voter. It votes NCH request channels from three redundant harts, with zero added latency on the bus path. Per-hart persistence counters drive a mode FSM:
- A hart that mismatches THRESH consecutive cycles is excluded, and the block degrades to dual-lockstep compare.
- Any further disagreement is fatal.
The block sits between the three cores' OBI request ports and the bus, and reports registered status to the safety controller.

Parameters:
NHARTS, 3, redundant harts; only 3 is supported, and elaboration fails otherwise.
NCH, 2, voted request channels (0 = instr, 1 = data).
CNT_W, 4, width of the per-hart consecutive-mismatch counter.
THRESH, 3, consecutive mismatch cycles that declare a hart faulty; legal range 1..2^CNT_W-1.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
core_req_i  in  obi_req_t[NCH][NHARTS]  per-channel, per-hart requests.
voted_req_o  out  obi_req_t[NCH]  voted requests (combinational).
enable_i  in  1  checking enable; when low, no mismatch is counted.
resync_i  in  1  pulse: the harts have been resynchronised; return to TMR.
clear_i  in  1  pulse: clear error_status_o.
mode_o  out  2  0 = TMR, 1 = DEGRADED, 2 = FAIL.
faulty_hart_o  out  2  excluded hart index; valid in DEGRADED.
error_o  out  1  registered: a qualified mismatch occurred in the previous cycle.
error_status_o  out  NHARTS  sticky per-hart mismatch flags.
fatal_o  out  1  equals (mode_o == FAIL).

Behaviour:
- Compare rule, per channel c and hart h. m[c][h] is set when any of the following holds, and only while enable_i=1 and (voted req | hart req):
  - addr differs and the hart's req=1;
  - wdata differs and the hart's we=1;
  - be differs;
  - we differs;
  - req differs.
- hart_mis[h] is the OR of m[c][h] over all channels c.
- Vote path, per mode:
  - TMR: bitwise 2-of-3 majority on addr, wdata, we, be, req.
  - DEGRADED: output the lower-index non-excluded hart's request unchanged. The "voted" value used for comparison is that hart. The excluded hart is ignored.
  - FAIL: req=0 on every channel; other fields are don't-care (driven 0).
- Counters, one per hart, CNT_W bits:
  - hart_mis=1 increments the counter, saturating.
  - hart_mis=0 clears it to 0.
  - The excluded hart's counter is held at 0.
- FSM transitions, evaluated at the clock edge:
  - TMR -> DEGRADED when exactly one hart has cnt==THRESH-1 and hart_mis=1. faulty_hart_o latches that index.
  - TMR -> FAIL when two or more harts reach the threshold in the same cycle.
  - DEGRADED -> FAIL on any cycle where a remaining hart has hart_mis=1. There is no threshold in this mode.
  - DEGRADED or FAIL -> TMR on resync_i=1. All counters clear; faulty_hart_o returns to 0.
  - resync_i in the same cycle as a fault event: resync_i wins.
- error_o:
  - TMR: registered OR of all hart_mis.
  - DEGRADED: OR over the remaining harts only.
  - FAIL: 0.
- error_status_o:
  - A bit is set on the corresponding hart_mis.
  - clear_i clears all bits.
  - A set and a clear in the same cycle leave the bit at 1.
- Status latency: one cycle. The vote path has zero cycles of latency.
- enable_i=0: the FSM holds its state, counters clear, and error_o=0.
- Reset values: mode_o=0, faulty_hart_o=0, error_o=0, error_status_o=0, fatal_o=0, all counters 0.
- Reset asserted mid-DEGRADED or mid-FAIL returns the block to TMR immediately (asynchronous reset).

Decomposition:
- cei_mochila_pkg gains:
  - voter_mode_e enum (TMR, DEGRADED, FAIL), 2 bits;
  - hart_idx_t, 2 bits.
- One sub-module, tmr_voter_lane. It takes three obi_req_t inputs, mode and the excluded index, and produces the voted obi_req_t and m[2:0]. It is instantiated NCH times.
- The FSM, counters and status registers live in the top module.

Test Plan:
1. All harts drive ch0 req=1, addr=0x100, be=0xF -> voted addr=0x100 and req=1; error_o stays 0; mode_o=0.
2. Hart1 addr=0x104 (others 0x100) for 1 cycle -> voted addr=0x100. Next cycle: error_o=1, error_status_o=3'b010, mode_o=0. Hart1's counter returns to 0 after a clean cycle.
3. Hart2 wdata=0xDEAD with we=1 (others 0xBEEF) for 3 cycles -> after the 3rd edge: mode_o=1, faulty_hart_o=2, voted_req_o equals hart0. The same wdata mismatch with we=0 produces no error.
4. In DEGRADED(2), hart1 be=0x3 vs hart0 be=0xF for 1 cycle -> next cycle: mode_o=2, fatal_o=1, voted req=0 on all channels.
5. resync_i pulse in FAIL -> next cycle: mode_o=0, fatal_o=0, counters 0; error_status_o is retained until clear_i. clear_i coincident with a new hart0 mismatch leaves bit0 set.
6. All three harts drive different addrs for 3 cycles -> mode_o=2 directly. A separate run asserts rst_i mid-DEGRADED -> mode_o=0 and all status outputs return to 0 immediately.
